pwm_timer_multi: RTL and testbench

//  APB-mapped multi-channel PWM generator; next generation of the SoC PWM peripheral.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_timer_chan.sv | 96 +++++++++
 rtl/pwm_timer_multi.sv | 105 ++++++++++
 tb/tb_pwm_timer_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared register map, CTRL bit positions and helpers for the multi-channel PWM timer.
package pwm_pkg;

  localparam int REGS_PER_CHAN = 4;
  localparam int CTRL_W        = 4;

  // Byte offsets inside one channel window
  localparam logic [3:0] OFF_PERIOD = 4'h0;
  localparam logic [3:0] OFF_DUTY   = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_COUNT  = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_CENTRE = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam logic [7:0] STATUS_OFF = 8'h80;

  function automatic logic [7:0] chan_base(input int unsigned n);
    return 8'(n * REGS_PER_CHAN * 4);
  endfunction

endpackage

// File: rtl/pwm_timer_chan.sv
// One PWM channel: shadow/active period and duty, edge/centre counter, boundary pulse
// and the registered output.
module pwm_timer_chan
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_period,
  input  logic              wr_duty,
  input  logic              wr_ctrl,
  input  logic [CNT_W-1:0]  wdata,
  output logic [CNT_W-1:0]  period_shadow,
  output logic [CNT_W-1:0]  duty_shadow,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  count,
  output logic              boundary,
  output logic              pwm_out
);

  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] duty_act;
  logic [CNT_W-1:0] count_next;
  logic             dir_down;
  logic             dir_down_next;
  logic             step_down;
  logic             at_top;
  logic             en;
  logic             inv;
  logic             centre;

  assign en     = ctrl[CTRL_EN];
  assign inv    = ctrl[CTRL_INV];
  assign centre = ctrl[CTRL_CENTRE];
  assign at_top = (count >= period_act - CNT_W'(1));

  always_comb begin
    count_next    = count;
    dir_down_next = dir_down;
    step_down     = 1'b0;
    boundary      = 1'b0;
    if (!en) begin
      count_next    = '0;
      dir_down_next = 1'b0;
    end else if (period_act <= CNT_W'(1)) begin
      // Degenerate periods hold the counter; only P=1 edge mode wraps every clock
      count_next    = '0;
      dir_down_next = 1'b0;
      boundary      = (period_act == CNT_W'(1)) && !centre;
    end else if (!centre) begin
      dir_down_next = 1'b0;
      if (at_top) begin
        count_next = '0;
        boundary   = 1'b1;
      end else begin
        count_next = count + CNT_W'(1);
      end
    end else begin
      step_down = dir_down || at_top;
      if (step_down) begin
        count_next    = count - CNT_W'(1);
        boundary      = (count == CNT_W'(1));
        dir_down_next = (count != CNT_W'(1));
      end else begin
        count_next = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_shadow <= '0;
      duty_shadow   <= '0;
      period_act    <= '0;
      duty_act      <= '0;
      ctrl          <= '0;
      count         <= '0;
      dir_down      <= 1'b0;
      pwm_out       <= 1'b0;
    end else begin
      count    <= count_next;
      dir_down <= dir_down_next;
      pwm_out  <= en ? ((count < duty_act) ^ inv) : inv;
      if (wr_ctrl)   ctrl          <= wdata[CTRL_W-1:0];
      if (wr_period) period_shadow <= wdata;
      if (wr_duty)   duty_shadow   <= wdata;
      // A write landing on the load cycle is forwarded so it is not held off a whole period
      if (!en || boundary) begin
        period_act <= wr_period ? wdata : period_shadow;
        duty_act   <= wr_duty   ? wdata : duty_shadow;
      end
    end
  end

endmodule

// File: rtl/pwm_timer_multi.sv
// APB-mapped multi-channel PWM timer: bus decode, read mux, W1C STATUS and level irq
// around one pwm_timer_chan per channel.
module pwm_timer_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [31:0]             paddr,
  input  logic [31:0]             pwdata,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  output logic [31:0]             prdata,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic                    irq
);

  logic                    wr_access;
  logic                    status_hit;
  logic [NUM_CHANNELS-1:0] chan_hit;
  logic [NUM_CHANNELS-1:0] boundary;
  logic [NUM_CHANNELS-1:0] irq_en_vec;
  logic [NUM_CHANNELS-1:0] status_reg;
  logic [NUM_CHANNELS-1:0] status_next;
  logic [NUM_CHANNELS-1:0] w1c_mask;
  logic [CNT_W-1:0]        period_sh [NUM_CHANNELS];
  logic [CNT_W-1:0]        duty_sh   [NUM_CHANNELS];
  logic [CNT_W-1:0]        count_val [NUM_CHANNELS];
  logic [CTRL_W-1:0]       ctrl_val  [NUM_CHANNELS];
  logic                    unused_paddr;

  assign wr_access    = psel & penable & pwrite;
  assign status_hit   = (paddr[7:0] == STATUS_OFF);
  assign unused_paddr = ^paddr[31:8];

  generate
    if (CNT_W < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^pwdata[31:CNT_W];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      localparam logic [7:0] BASE = chan_base(gi);
      assign chan_hit[gi]   = ({paddr[7:4], 4'h0} == BASE);
      assign irq_en_vec[gi] = ctrl_val[gi][CTRL_IRQ_EN];

      pwm_timer_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk           (clk),
        .n_rst         (n_rst),
        .wr_period     (wr_access && chan_hit[gi] && (paddr[3:0] == OFF_PERIOD)),
        .wr_duty       (wr_access && chan_hit[gi] && (paddr[3:0] == OFF_DUTY)),
        .wr_ctrl       (wr_access && chan_hit[gi] && (paddr[3:0] == OFF_CTRL)),
        .wdata         (pwdata[CNT_W-1:0]),
        .period_shadow (period_sh[gi]),
        .duty_shadow   (duty_sh[gi]),
        .ctrl          (ctrl_val[gi]),
        .count         (count_val[gi]),
        .boundary      (boundary[gi]),
        .pwm_out       (pwm_out[gi])
      );
    end
  endgenerate

  // A boundary in the same cycle as a W1C keeps the flag set
  always_comb begin
    w1c_mask    = (wr_access && status_hit) ? pwdata[NUM_CHANNELS-1:0] : '0;
    status_next = boundary | (status_reg & ~w1c_mask);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      status_reg <= '0;
    end else begin
      status_reg <= status_next;
    end
  end

  assign irq = |(status_reg & irq_en_vec);

  always_comb begin
    prdata = '0;
    if (psel) begin
      if (status_hit) prdata = 32'(status_reg);
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (chan_hit[i]) begin
          case (paddr[3:0])
            OFF_PERIOD: prdata = 32'(period_sh[i]);
            OFF_DUTY:   prdata = 32'(duty_sh[i]);
            OFF_CTRL:   prdata = 32'(ctrl_val[i]);
            OFF_COUNT:  prdata = 32'(count_val[i]);
            default:    prdata = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Self-checking bench for pwm_timer_multi: scoreboard queue of expected values,
// table of duty/polarity corner vectors, and hand-timed shadow/centre/irq/reset sequences.
module tb_pwm_timer_multi;

  localparam int NCH = 2;
  localparam int CW  = 16;

  localparam logic [31:0] A_PERIOD0 = 32'h00;
  localparam logic [31:0] A_DUTY0   = 32'h04;
  localparam logic [31:0] A_CTRL0   = 32'h08;
  localparam logic [31:0] A_COUNT0  = 32'h0C;
  localparam logic [31:0] A_PERIOD1 = 32'h10;
  localparam logic [31:0] A_DUTY1   = 32'h14;
  localparam logic [31:0] A_CTRL1   = 32'h18;
  localparam logic [31:0] A_COUNT1  = 32'h1C;
  localparam logic [31:0] A_STATUS  = 32'h80;
  localparam logic [31:0] A_UNMAP   = 32'h90;

  logic            clk     = 1'b0;
  logic            n_rst   = 1'b0;
  logic [31:0]     paddr   = '0;
  logic [31:0]     pwdata  = '0;
  logic            psel    = 1'b0;
  logic            penable = 1'b0;
  logic            pwrite  = 1'b0;
  logic [31:0]     prdata;
  logic [NCH-1:0]  pwm_out;
  logic            irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [15:0] p;
    logic [15:0] d;
    logic [3:0]  ctrl;
    logic        lvl;
    logic        st;
    logic        cnt0;
  } vec_t;
  vec_t vecs[9];

  pwm_timer_multi #(
    .NUM_CHANNELS (NCH),
    .CNT_W        (CW)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .prdata  (prdata),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=%0h required=entry", act);
      return;
    end
    e = sb_q.pop_front();
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", e.name, act, e.exp);
    end else begin
      $display("ok   %s value=%0h", e.name, act);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("wr   addr=%02h data=%0h", a[7:0], d);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic apb_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    sb_push(name, exp);
    apb_read(a, d);
    sb_pop(d);
  endtask

  task automatic step_chk(input string name, input logic exp, input int ch);
    sb_push(name, {31'b0, exp});
    @(negedge clk);
    sb_pop({31'b0, pwm_out[ch]});
  endtask

  function automatic int centre_cnt(input int k);
    int m;
    m = k % 10;
    return (m <= 5) ? m : 10 - m;
  endfunction

  initial begin
    logic [31:0] rd;
    int          highs;
    logic [31:0] rst_addrs[10];

    vecs[0] = '{p:16'd10, d:16'd0,  ctrl:4'h1, lvl:1'b0, st:1'b1, cnt0:1'b0};
    vecs[1] = '{p:16'd10, d:16'd10, ctrl:4'h1, lvl:1'b1, st:1'b1, cnt0:1'b0};
    vecs[2] = '{p:16'd10, d:16'd0,  ctrl:4'h3, lvl:1'b1, st:1'b1, cnt0:1'b0};
    vecs[3] = '{p:16'd10, d:16'd10, ctrl:4'h3, lvl:1'b0, st:1'b1, cnt0:1'b0};
    vecs[4] = '{p:16'd10, d:16'd3,  ctrl:4'h0, lvl:1'b0, st:1'b0, cnt0:1'b1};
    vecs[5] = '{p:16'd10, d:16'd3,  ctrl:4'h2, lvl:1'b1, st:1'b0, cnt0:1'b1};
    vecs[6] = '{p:16'd0,  d:16'd5,  ctrl:4'h1, lvl:1'b1, st:1'b0, cnt0:1'b1};
    vecs[7] = '{p:16'd1,  d:16'd0,  ctrl:4'h3, lvl:1'b1, st:1'b1, cnt0:1'b1};
    vecs[8] = '{p:16'd1,  d:16'd1,  ctrl:4'h5, lvl:1'b1, st:1'b0, cnt0:1'b1};

    rst_addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h80, 32'h90};

    // Reset state
    repeat (3) @(negedge clk);
    sb_push("rst_pwm_out", 32'h0); sb_pop(32'(pwm_out));
    sb_push("rst_irq", 32'h0);     sb_pop(32'(irq));
    sb_push("rst_prdata_idle", 32'h0); sb_pop(prdata);
    n_rst = 1'b1;
    @(negedge clk);
    apb_read_chk("rst_period0", A_PERIOD0, 32'h0);

    // Edge mode P=10 D=3: 3 high of every 10, count 0..9
    apb_write(A_PERIOD0, 32'd10);
    apb_write(A_DUTY0, 32'd3);
    apb_write(A_CTRL0, 32'h1);
    apb_read_chk("t1_count_start", A_COUNT0, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step_chk("t1_pwm", ((k - 1) % 10) < 3, 0);
      apb_read_chk("t1_count", A_COUNT0, 32'(k % 10));
    end
    apb_read(A_STATUS, rd);
    sb_push("t1_status0", 32'h1); sb_pop(rd & 32'h1);

    // Duty shadowing: write 7 early in a period, current period keeps 3
    apb_write(A_DUTY0, 32'd7);
    apb_read_chk("t2_duty_readback", A_DUTY0, 32'd7);
    for (int k = 24; k <= 40; k++) begin
      step_chk("t2_pwm", ((k - 1) % 10) < ((k <= 30) ? 3 : 7), 0);
      apb_read_chk("t2_count", A_COUNT0, 32'(k % 10));
    end

    // Centre mode on channel 1: P=6 D=2, 10-clock cycle
    apb_write(A_PERIOD1, 32'd6);
    apb_write(A_DUTY1, 32'd2);
    apb_write(A_CTRL1, 32'h5);
    for (int k = 1; k <= 20; k++) begin
      step_chk("t3_pwm", centre_cnt(k - 1) < 2, 1);
      apb_read_chk("t3_count", A_COUNT1, 32'(centre_cnt(k)));
    end
    apb_read_chk("t3_ctrl1", A_CTRL1, 32'h5);
    apb_read_chk("unmapped_read", A_UNMAP, 32'h0);

    // Duty / polarity / enable / degenerate-period vectors on channel 0
    for (int v = 0; v < 9; v++) begin
      apb_write(A_CTRL0, 32'h0);
      apb_write(A_STATUS, 32'h1);
      apb_write(A_PERIOD0, 32'(vecs[v].p));
      apb_write(A_DUTY0, 32'(vecs[v].d));
      apb_write(A_CTRL0, 32'(vecs[v].ctrl));
      repeat (2) @(negedge clk);
      highs = 0;
      for (int s = 0; s < 12; s++) begin
        @(negedge clk);
        if (pwm_out[0] === 1'b1) highs++;
      end
      sb_push($sformatf("vec%0d_high_samples", v), vecs[v].lvl ? 32'd12 : 32'd0);
      sb_pop(32'(highs));
      apb_read(A_STATUS, rd);
      sb_push($sformatf("vec%0d_status0", v), {31'b0, vecs[v].st});
      sb_pop(rd & 32'h1);
      if (vecs[v].cnt0) apb_read_chk($sformatf("vec%0d_count", v), A_COUNT0, 32'h0);
    end

    // IRQ and W1C on channel 0
    apb_write(A_CTRL0, 32'h0);
    apb_write(A_STATUS, 32'h1);
    apb_write(A_PERIOD0, 32'd10);
    apb_write(A_DUTY0, 32'd3);
    apb_write(A_CTRL0, 32'h9);
    for (int k = 1; k <= 17; k++) begin
      sb_push("t5_irq", {31'b0, k >= 10});
      @(negedge clk);
      sb_pop(32'(irq));
    end
    apb_write(A_STATUS, 32'h1);
    apb_read(A_STATUS, rd);
    sb_push("t5_w1c_on_boundary_status0", 32'h1); sb_pop(rd & 32'h1);
    sb_push("t5_w1c_on_boundary_irq", 32'h1);     sb_pop(32'(irq));
    apb_write(A_STATUS, 32'h1);
    sb_push("t5_w1c_irq_drop", 32'h0); sb_pop(32'(irq));
    apb_read_chk("t5_status_after_w1c", A_STATUS, 32'h2);
    for (int k = 24; k <= 30; k++) begin
      sb_push("t5_irq_again", {31'b0, k >= 30});
      @(negedge clk);
      sb_pop(32'(irq));
    end
    @(negedge clk);
    sb_push("t6_pwm_before_reset", 32'h1); sb_pop({31'b0, pwm_out[0]});

    // Asynchronous reset mid-period
    #2;
    n_rst = 1'b0;
    #1;
    sb_push("t6_rst_pwm_out", 32'h0); sb_pop(32'(pwm_out));
    sb_push("t6_rst_irq", 32'h0);     sb_pop(32'(irq));
    for (int i = 0; i < 10; i++) begin
      apb_read_chk($sformatf("t6_rst_read_%02h", rst_addrs[i][7:0]), rst_addrs[i], 32'h0);
    end
    sb_push("t6_prdata_idle", 32'h0); sb_pop(prdata);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    apb_read_chk("t6_post_ctrl0", A_CTRL0, 32'h0);
    apb_read_chk("t6_post_count0", A_COUNT0, 32'h0);
    sb_push("t6_post_pwm_out", 32'h0); sb_pop(32'(pwm_out));

    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
